// File: rtl/blake2_pkg.sv
// Shared types and per-variant sizing for the blake2 message feeder.
// Variant helpers return block size, digest length and compression gap for blake2b / blake2s.
package blake2_pkg;

  typedef enum logic {VAR_B, VAR_S} variant_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_DRAIN = 3'd2,
    S_GAP   = 3'd3,
    S_RES   = 3'd4
  } state_t;

  function automatic int bb_of(input variant_t v);
    return (v == VAR_S) ? 64 : 128;
  endfunction

  function automatic int nn_of(input variant_t v);
    return (v == VAR_S) ? 32 : 64;
  endfunction

  // Core needs (R+1)*8+2 idle cycles after a block; R = 12 for b, 10 for s.
  function automatic int gap_of(input variant_t v);
    return (v == VAR_S) ? (10 + 1) * 8 + 2 : (12 + 1) * 8 + 2;
  endfunction

  function automatic int idx_w(input int bb);
    return $clog2(bb);
  endfunction

endpackage

// File: rtl/blake2_block_buf.sv
// BB x 8 block storage; synchronous write, combinational padded read (bytes at or beyond fill read as 00).
// Zero read latency; no flow control of its own.
module blake2_block_buf
  import blake2_pkg::*;
#(
  parameter int  BB    = 128,
  localparam int IDX_W = idx_w(BB)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [IDX_W:0]   fill,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [BB];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = ({1'b0, rd_idx} < fill) ? mem[rd_idx] : 8'h00;

endmodule

// File: rtl/blake2_msg_feeder.sv
// Packs a byte-stream message into zero-padded blocks for the blake2 core and re-frames its digest.
// s_ready_o drops while a block drains, through the inter-block gap and digest return; res_v_o has no backpressure.
module blake2_msg_feeder
  import blake2_pkg::*;
#(
  parameter int  BB         = bb_of(VAR_B),
  parameter int  NN         = nn_of(VAR_B),
  parameter int  GAP_CYCLES = gap_of(VAR_B),
  localparam int IDX_W      = idx_w(BB)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [7:0]       s_data_i,
  input  logic             s_last_i,
  output logic             data_v_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic [7:0]       data_o,
  output logic             block_first_o,
  output logic             block_last_o,
  output logic [BB-1:0]    ll_o,
  output logic [7:0]       kk_o,
  output logic [7:0]       nn_o,
  input  logic             finished_i,
  input  logic [7:0]       h_i,
  output logic             res_v_o,
  output logic [7:0]       res_data_o,
  output logic             res_last_o,
  output logic             busy_o
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int RES_W = (NN > 1) ? $clog2(NN) : 1;

  state_t           state, state_nxt;
  logic [IDX_W:0]   fill;
  logic [IDX_W-1:0] idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [RES_W-1:0] res_cnt;
  logic [BB-1:0]    ll;
  logic             last_seen, first_pend, fin_d;
  logic             fill_full, idx_end, gap_end, res_end, acc;

  assign fill_full = (fill == (IDX_W+1)'(BB));
  assign idx_end   = (idx == IDX_W'(BB - 1));
  assign gap_end   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign res_end   = (res_cnt == RES_W'(NN - 1));
  assign acc       = s_valid_i & s_ready_o;

  always_comb begin
    state_nxt  = state;
    s_ready_o  = 1'b0;
    data_v_o   = 1'b0;
    res_v_o    = 1'b0;
    res_last_o = 1'b0;
    case (state)
      S_IDLE: begin
        s_ready_o = 1'b1;
        if (s_valid_i) state_nxt = s_last_i ? S_DRAIN : S_FILL;
      end
      S_FILL: begin
        s_ready_o = ~fill_full;
        // A valid byte seen with a full buffer is held back as lookahead: more data follows.
        if (s_valid_i && (fill_full || s_last_i)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        data_v_o = 1'b1;
        if (idx_end) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_end) state_nxt = last_seen ? S_RES : S_FILL;
      end
      S_RES: begin
        res_v_o    = fin_d;
        res_last_o = fin_d & res_end;
        if (fin_d && res_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) s_ready_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      fill       <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      res_cnt    <= '0;
      ll         <= '0;
      last_seen  <= 1'b0;
      first_pend <= 1'b0;
      fin_d      <= 1'b0;
    end else begin
      state <= state_nxt;
      fin_d <= finished_i;
      if (acc) begin
        fill <= fill + 1'b1;
        if (state == S_IDLE) begin
          ll         <= BB'(1);
          first_pend <= 1'b1;
          last_seen  <= s_last_i;
        end else begin
          if (~&ll) ll <= ll + 1'b1;
          if (s_last_i) last_seen <= 1'b1;
        end
      end
      if (state == S_DRAIN) begin
        idx <= idx_end ? '0 : idx + 1'b1;
        if (idx_end) begin
          first_pend <= 1'b0;
          fill       <= '0;
        end
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      if (res_v_o) begin
        res_cnt <= res_end ? '0 : res_cnt + 1'b1;
        if (res_end) ll <= '0;
      end
    end
  end

  blake2_block_buf #(.BB(BB)) u_buf (
    .clk     (clk),
    .wr_en   (acc),
    .wr_idx  (fill[IDX_W-1:0]),
    .wr_data (s_data_i),
    .rd_idx  (idx),
    .fill    (fill),
    .rd_data (data_o)
  );

  assign data_idx_o    = idx;
  assign block_first_o = data_v_o & first_pend;
  assign block_last_o  = data_v_o & last_seen;
  assign ll_o          = ll;
  assign kk_o          = 8'h00;
  assign nn_o          = 8'(NN);
  assign res_data_o    = res_v_o ? h_i : 8'h00;
  assign busy_o        = (state != S_IDLE);

endmodule

// File: tb/tb_blake2_msg_feeder.sv
// Directed/randomised bench for blake2_msg_feeder with a message-level block model and a stub core.
module tb_blake2_msg_feeder;

  localparam int BB = 128, NN = 64, GAP = 106, IDX_W = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid_i, s_ready_o, s_last_i;
  logic [7:0]       s_data_i;
  logic             data_v_o;
  logic [IDX_W-1:0] data_idx_o;
  logic [7:0]       data_o;
  logic             block_first_o, block_last_o;
  logic [BB-1:0]    ll_o;
  logic [7:0]       kk_o, nn_o;
  logic             finished_i;
  logic [7:0]       h_i;
  logic             res_v_o, res_last_o, busy_o;
  logic [7:0]       res_data_o;

  blake2_msg_feeder #(.BB(BB), .NN(NN), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .data_v_o(data_v_o), .data_idx_o(data_idx_o), .data_o(data_o),
    .block_first_o(block_first_o), .block_last_o(block_last_o),
    .ll_o(ll_o), .kk_o(kk_o), .nn_o(nn_o),
    .finished_i(finished_i), .h_i(h_i),
    .res_v_o(res_v_o), .res_data_o(res_data_o), .res_last_o(res_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference state: pending message bytes (concatenated) and their lengths.
  logic [7:0] stream[$];
  int         lens[$];
  logic [7:0] abc_ref [8] = '{8'hBA, 8'h80, 8'hA5, 8'h3F, 8'h98, 8'h1C, 8'h4D, 8'h0D};
  logic [7:0] dig [NN];
  logic [7:0] got_res [NN];
  logic [7:0] got_blk [BB];
  bit         use_abc = 1'b0;
  int         dig_req_cnt = 0, dig_served = 0, res_done_cnt = 0;
  int         last_res_cyc = 0, first_acc_cyc = 0;

  int         mon_blk = 0, mon_idx = 0, rcnt = 0, gap_len = 0;
  int         idx_err = 0, unstable = 0, rdy_hi = 0, rdy_hi_res = 0;
  bit         in_gap = 1'b0, wait_res = 1'b0;
  logic       b_first, b_last;
  logic [BB-1:0] b_ll;

  task automatic check_block();
    int len, nb, nbad;
    logic [7:0] e;
    len  = (lens.size() > 0) ? lens[0] : 0;
    nb   = (len + BB - 1) / BB;
    nbad = 0;
    for (int i = 0; i < BB; i++) begin
      e = (mon_blk * BB + i < len) ? stream[mon_blk * BB + i] : 8'h00;
      if (got_blk[i] !== e) nbad++;
    end
    chk("blk_expected", 128'(len > 0), 128'(1));
    chk("blk_bad_bytes", 128'(nbad), 128'(0));
    chk("blk_idx_seq", 128'(idx_err), 128'(0));
    chk("blk_ctl_stable", 128'(unstable), 128'(0));
    chk("blk_ready_low", 128'(rdy_hi), 128'(0));
    chk("blk_first", 128'(b_first), 128'(mon_blk == 0));
    chk("blk_last", 128'(b_last), 128'(mon_blk == nb - 1));
    if (mon_blk == nb - 1) chk("blk_ll", b_ll, 128'(len));
    if (b_last) begin
      wait_res    = 1'b1;
      rdy_hi_res  = 0;
      dig_req_cnt++;
    end else begin
      in_gap  = 1'b1;
      gap_len = 0;
    end
    mon_blk++;
  endtask

  task automatic finish_msg();
    int len;
    len = (lens.size() > 0) ? lens[0] : 0;
    chk("res_ready_low", 128'(rdy_hi_res), 128'(0));
    chk("msg_blocks", 128'(mon_blk), 128'((len + BB - 1) / BB));
    last_res_cyc = cyc;
    res_done_cnt++;
    wait_res = 1'b0;
    mon_blk  = 0;
    rcnt     = 0;
    repeat (len) void'(stream.pop_front());
    if (lens.size() > 0) void'(lens.pop_front());
  endtask

  // Monitor: block collection, gap length, digest stream.
  always @(negedge clk) begin
    if (reset) begin
      mon_blk = 0; mon_idx = 0; rcnt = 0; in_gap = 1'b0; wait_res = 1'b0;
      stream.delete(); lens.delete();
    end else begin
      if (in_gap) begin
        if (!data_v_o && !s_ready_o) gap_len++;
        else begin
          chk("gap_ge_106", 128'(gap_len >= GAP), 128'(1));
          in_gap = 1'b0;
        end
      end
      if (wait_res && s_ready_o) rdy_hi_res++;
      if (data_v_o) begin
        if (mon_idx == 0) begin
          b_first = block_first_o; b_last = block_last_o; b_ll = ll_o;
          idx_err = 0; unstable = 0; rdy_hi = 0;
        end
        if (data_idx_o !== IDX_W'(mon_idx)) idx_err++;
        if (block_first_o !== b_first || block_last_o !== b_last || ll_o !== b_ll) unstable++;
        if (s_ready_o) rdy_hi++;
        got_blk[mon_idx] = data_o;
        mon_idx++;
        if (mon_idx == BB) begin
          check_block();
          mon_idx = 0;
        end
      end
      if (res_v_o) begin
        chk("res_expected", 128'(wait_res), 128'(1));
        chk("res_byte", 128'(res_data_o), 128'(dig[rcnt]));
        chk("res_last", 128'(res_last_o), 128'(rcnt == NN - 1));
        got_res[rcnt] = res_data_o;
        rcnt++;
        if (rcnt == NN || res_last_o) finish_msg();
      end
    end
  end

  // Stub core: after the compression delay, stream NN digest bytes; h_i lags finished_i by one cycle.
  initial begin
    finished_i = 1'b0;
    h_i        = 8'h00;
    forever begin
      @(posedge clk);
      if (dig_req_cnt != dig_served) begin
        dig_served++;
        for (int k = 0; k < NN; k++) dig[k] = (use_abc && k < 8) ? abc_ref[k] : 8'($urandom);
        repeat (GAP + $urandom_range(0, 4)) @(posedge clk);
        #1;
        for (int k = 0; k <= NN; k++) begin
          finished_i = (k < NN);
          h_i        = (k > 0) ? dig[k-1] : 8'h00;
          @(posedge clk);
          #1;
        end
        finished_i = 1'b0;
        h_i        = 8'h00;
      end
    end
  end

  task automatic send(input int len, input bit tog, input bit fixed_abc);
    logic [7:0] m[$];
    int  i, stall;
    bit  acc;
    i = 0;
    stall = 0;
    for (int k = 0; k < len; k++) m.push_back(fixed_abc ? 8'h61 + 8'(k) : 8'($urandom));
    for (int k = 0; k < len; k++) stream.push_back(m[k]);
    lens.push_back(len);
    @(posedge clk);
    #1;
    while (i < len && stall < 3000) begin
      s_valid_i = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = m[i];
      s_last_i  = (i == len - 1);
      @(negedge clk);
      acc = s_valid_i && s_ready_o;
      if (acc && i == 0) first_acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (acc) begin i++; stall = 0; end
      else stall++;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_data_i  = 8'h00;
    chk("drv_bytes_taken", 128'(i), 128'(len));
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (res_done_cnt < target && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("msg_done", 128'(res_done_cnt >= target), 128'(1));
    @(negedge clk);
  endtask

  initial begin
    int  t, lra, nmsg;
    bit  found;
    reset     = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    s_last_i  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'(s_ready_o), 128'(0));
    chk("rst_data_v", 128'(data_v_o), 128'(0));
    chk("rst_res_v", 128'(res_v_o), 128'(0));
    chk("rst_res_last", 128'(res_last_o), 128'(0));
    chk("rst_first", 128'(block_first_o), 128'(0));
    chk("rst_last", 128'(block_last_o), 128'(0));
    chk("rst_ll", ll_o, 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("kk_const", 128'(kk_o), 128'(0));
    chk("nn_const", 128'(nn_o), 128'(NN));
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 128'(s_ready_o), 128'(1));
    chk("idle_busy", 128'(busy_o), 128'(0));

    use_abc = 1'b1;
    send(3, 1'b0, 1'b1);
    wait_done(1);
    use_abc = 1'b0;
    for (int k = 0; k < 8; k++) chk("abc_digest", 128'(got_res[k]), 128'(abc_ref[k]));
    chk("post_msg_busy", 128'(busy_o), 128'(0));
    chk("post_msg_ll", ll_o, 128'(0));

    send(128, 1'b0, 1'b0);
    wait_done(2);
    send(129, 1'b0, 1'b0);
    wait_done(3);
    nmsg = 3;
    for (int m = 0; m < 4; m++) begin
      send($urandom_range(1, 300), 1'b1, 1'b0);
      nmsg++;
      wait_done(nmsg);
    end

    // Abort a message partway through its drain.
    send(100, 1'b1, 1'b0);
    t = 0;
    found = 1'b0;
    while (!found && t < 2000) begin
      @(negedge clk);
      t++;
      if (data_v_o && data_idx_o == IDX_W'(50)) found = 1'b1;
    end
    chk("reach_idx50", 128'(found), 128'(1));
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_data_v", 128'(data_v_o), 128'(0));
    chk("abort_ready", 128'(s_ready_o), 128'(0));
    chk("abort_busy", 128'(busy_o), 128'(0));
    chk("abort_ll", ll_o, 128'(0));
    #1 reset = 1'b0;

    use_abc = 1'b1;
    send(3, 1'b0, 1'b1);
    nmsg++;
    wait_done(nmsg);
    use_abc = 1'b0;

    // Back-to-back: second message is offered while the first is still in flight.
    send($urandom_range(1, 200), 1'b0, 1'b0);
    send($urandom_range(1, 200), 1'b1, 1'b0);
    lra = last_res_cyc;
    chk("b2b_first_done", 128'(res_done_cnt), 128'(nmsg + 1));
    chk("b2b_order", 128'(first_acc_cyc > lra), 128'(1));
    nmsg += 2;
    wait_done(nmsg);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
